// File: rtl/physical_word_align.sv
// rtl/physical_word_align.sv - comma-search word aligner driving the gearbox bitslip offset
module physical_word_align #(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 8,
    parameter logic [9:0] COMMA_N       = 10'b0011111010,
    parameter logic [9:0] COMMA_P       = 10'b1100000101,
    parameter bit         AUTO_START    = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_data,
    input  logic       i_align_start,
    output logic [3:0] o_slipbits,
    output logic       o_aligned,
    output logic       o_align_error,
    output logic [9:0] o_data,
    output logic       o_data_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  slip_q, slip_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic        aligned_q, aligned_d;
    logic        error_q, error_d;
    logic [9:0]  data_q;
    logic        is_comma;

    assign is_comma = (i_data == COMMA_N) || (i_data == COMMA_P);

    always_comb begin
        state_d      = state_q;
        slip_d       = slip_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        error_d      = 1'b0;
        // A restart wins over lock completion and over the wrap error pulse.
        if (i_align_start) begin
            state_d      = S_SETTLE;
            slip_d       = 4'd0;
            settle_cnt_d = 4'd0;
            match_cnt_d  = 8'd0;
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) begin
                        state_d      = S_CHECK;
                        settle_cnt_d = 4'd0;
                        match_cnt_d  = 8'd0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (!is_comma) begin
                        state_d     = S_SLIP;
                        match_cnt_d = 8'd0;
                    end else if (match_cnt_q == 8'(MATCH_COUNT - 1)) begin
                        state_d = S_LOCKED;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end
                S_SLIP: begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = 4'd0;
                    if (slip_q == 4'd9) begin
                        slip_d  = 4'd0;
                        error_d = 1'b1;
                    end else begin
                        slip_d = slip_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lock is reported one cycle after the final matching word was counted.
    assign aligned_d = (state_q == S_LOCKED) && !i_align_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= AUTO_START ? S_SETTLE : S_IDLE;
            slip_q       <= 4'd0;
            settle_cnt_q <= 4'd0;
            match_cnt_q  <= 8'd0;
            aligned_q    <= 1'b0;
            error_q      <= 1'b0;
            data_q       <= 10'd0;
        end else begin
            state_q      <= state_d;
            slip_q       <= slip_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            aligned_q    <= aligned_d;
            error_q      <= error_d;
            data_q       <= i_data;
        end
    end

    assign o_slipbits    = slip_q;
    assign o_aligned     = aligned_q;
    assign o_data_valid  = aligned_q;
    assign o_align_error = error_q;
    assign o_data        = data_q;

endmodule

// File: tb/tb_physical_word_align.sv
// tb/tb_physical_word_align.sv - randomized scoreboard bench for physical_word_align
module tb_physical_word_align;

    localparam int         S  = 4;
    localparam int         M  = 8;
    localparam logic [9:0] CN = 10'b0011111010;
    localparam logic [9:0] CP = 10'b1100000101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] din = 10'd0;
    logic [3:0] o_slipbits;
    logic       o_aligned;
    logic       o_align_error;
    logic [9:0] o_data;
    logic       o_data_valid;

    always #5 clk = ~clk;

    physical_word_align #(
        .SETTLE_CYCLES(S),
        .MATCH_COUNT  (M),
        .COMMA_N      (CN),
        .COMMA_P      (CP),
        .AUTO_START   (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (din),
        .i_align_start(start),
        .o_slipbits   (o_slipbits),
        .o_aligned    (o_aligned),
        .o_align_error(o_align_error),
        .o_data       (o_data),
        .o_data_valid (o_data_valid)
    );

    typedef struct {
        logic [9:0] data;
        logic [3:0] slip;
        logic       aligned;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic logic [9:0] rand_noncomma();
        logic [9:0] v;
        do v = 10'($urandom); while (v == CN || v == CP);
        return v;
    endfunction

    function automatic logic [9:0] rand_comma();
        return ($urandom_range(0, 1) == 1) ? CN : CP;
    endfunction

    function automatic logic [9:0] rand_any();
        return ($urandom_range(0, 1) == 1) ? rand_comma() : rand_noncomma();
    endfunction

    // Drive one edge worth of inputs and queue the outputs expected after that edge.
    task automatic step(input logic r, input logic s, input logic [9:0] d,
                        input logic [3:0] es, input logic ea, input logic ee);
        exp_t e;
        rst   = r;
        start = s;
        din   = d;
        e.data    = r ? 10'd0 : d;
        e.slip    = r ? 4'd0 : es;
        e.aligned = r ? 1'b0 : ea;
        e.err     = r ? 1'b0 : ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_any(), 4'd0, 1'b0, 1'b0);
    endtask

    // One search started by a pulse. Attempt n begins at relative edge st[n]; a bad
    // attempt shows r[n] commas after settling and then a non-comma, so it lasts
    // S + r[n] + 2 edges. Attempt t_good shows M commas and locks S + M + 1 edges in.
    // r_mode: 0 = no partial runs, 1 = random partial runs, 2 = five commas on attempt 0.
    task automatic run_search(input int t_good, input int r_mode, input int extra,
                              input int fixed_len, input bit zero_data);
        int r[32];
        int st[33];
        int len;
        int n;
        int i;
        logic [9:0] d;
        st[0] = 0;
        for (int k = 0; k < 32; k++) begin
            r[k] = (r_mode == 1) ? int'($urandom_range(0, M - 1)) :
                   (r_mode == 2 && k == 0) ? 5 : 0;
            st[k + 1] = st[k] + S + r[k] + 2;
        end
        len = (fixed_len > 0) ? fixed_len :
              ((t_good >= 0) ? st[t_good] + S + M + 1 : 0) + extra;
        step(1'b0, 1'b1, zero_data ? 10'd0 : rand_any(), 4'd0, 1'b0, 1'b0);
        for (int t = 1; t <= len; t++) begin
            n = 0;
            while (n != t_good && n < 31 && st[n + 1] <= t) n++;
            i = t - st[n];
            if (zero_data)                 d = 10'd0;
            else if (i <= S)               d = rand_any();
            else if (n == t_good)          d = (i <= S + M) ? rand_comma() : rand_any();
            else if (i <= S + r[n])        d = rand_comma();
            else                           d = rand_noncomma();
            step(1'b0, 1'b0, d, 4'(n % 10), (n == t_good) && (i >= S + M + 1),
                 (i == 0) && (n > 0) && (n % 10 == 0));
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (o_data !== e.data || o_slipbits !== e.slip || o_aligned !== e.aligned ||
                    o_data_valid !== e.aligned || o_align_error !== e.err) begin
                    n_bad++;
                    $display("FAIL outputs cycle %0d: got data=%h slip=%0d aligned=%b valid=%b err=%b, want data=%h slip=%0d aligned=%b err=%b",
                             cyc, o_data, o_slipbits, o_aligned, o_data_valid, o_align_error,
                             e.data, e.slip, e.aligned, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin : stimulus
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, CN, 4'd0, 1'b0, 1'b0);
        idle_steps(6);
        run_search(0, 0, 3, 0, 1'b0);
        run_search(7, 0, 3, 0, 1'b0);
        run_search(-1, 0, 130, 0, 1'b1);
        run_search(1, 2, 2, 0, 1'b0);
        for (int k = 0; k < 6; k++)
            run_search(int'($urandom_range(0, 14)), 1, int'($urandom_range(0, 5)), 0, 1'b0);
        run_search(0, 1, 0, S + 2, 1'b0);
        step(1'b1, 1'b0, rand_any(), 4'd0, 1'b0, 1'b0);
        idle_steps(5);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
